// File: rtl/ysyx_040750_arb_mux_nbit_msrc.sv
// ----------------------------------------------------------------------------
// ysyx_040750_arb_mux_nbit_msrc
// M-source arbitrating mux feeding a single registered output stage.
//
// Parameters:
//   N  - data width per source
//   M  - number of sources (M >= 2)
//   RR - 1: round-robin arbitration, 0: fixed priority (index 0 highest)
//
// Ports:
//   I_clk        - clock; all state updates on the rising edge
//   I_rst_n      - asynchronous active-low reset
//   I_in_valid   - per-source request valid              [M]
//   I_in_data    - source i data in bits [i*N +: N]      [N*M]
//   O_in_ready   - per-source accept, one-hot or zero    [M] (combinational)
//   O_out_valid  - output register holds a beat
//   O_out_data   - registered data of the held beat      [N]
//   O_out_grant  - one-hot source index of the held beat [M]
//   I_out_ready  - downstream accept
// ----------------------------------------------------------------------------
module ysyx_040750_arb_mux_nbit_msrc #(
  parameter int unsigned N  = 64,
  parameter int unsigned M  = 4,
  parameter int unsigned RR = 1
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  input  logic [M-1:0]   I_in_valid,
  input  logic [N*M-1:0] I_in_data,
  output logic [M-1:0]   O_in_ready,
  output logic           O_out_valid,
  output logic [N-1:0]   O_out_data,
  output logic [M-1:0]   O_out_grant,
  input  logic           I_out_ready
);

  // Pointer reset value: source M-1 was "last", so source 0 leads after reset.
  localparam logic [M-1:0] PTR_RST = {1'b1, {(M-1){1'b0}}};

  logic [M-1:0] ptr;
  logic [M-1:0] above_ptr;
  logic [M-1:0] masked_req;
  logic [M-1:0] pick_req;
  logic [M-1:0] grant;
  logic [N-1:0] sel_data;
  logic         load_en;
  logic         xfer;

  // One-hot grant. Round-robin masks off the pointer and everything below it;
  // if no request remains above the pointer the search wraps to the full
  // request vector. Lowest set bit is isolated with x & -x.
  always_comb begin
    above_ptr  = ~(ptr | (ptr - M'(1)));
    masked_req = I_in_valid & above_ptr;
    pick_req   = I_in_valid;
    if ((RR != 0) && (masked_req != '0)) begin
      pick_req = masked_req;
    end
    grant = pick_req & (~pick_req + M'(1));
  end

  // Output stage can take a new beat when empty or being drained this cycle.
  assign load_en    = ~O_out_valid | I_out_ready;
  assign O_in_ready = I_rst_n ? (grant & {M{load_en}}) : '0;
  assign xfer       = |O_in_ready;

  // AND-OR mux of the granted source's data (grant is one-hot or zero).
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(M); i++) begin
      if (grant[i]) begin
        sel_data = sel_data | I_in_data[i*N +: N];
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_out_valid <= 1'b0;
      O_out_data  <= '0;
      O_out_grant <= '0;
      ptr         <= PTR_RST;
    end else if (xfer) begin
      O_out_valid <= 1'b1;
      O_out_data  <= sel_data;
      O_out_grant <= O_in_ready;
      ptr         <= O_in_ready;
    end else if (I_out_ready) begin
      O_out_valid <= 1'b0;
    end
  end

endmodule
